ad5766_offload_ctrl: RTL and testbench

Sequencer for the AD5766 SPI-engine offload command memory. It runs on ctrl_clk beside the DAC offload core. It clears the command memory, loads a program of command words from a valid/ready word stream, and arms or disarms the offload through the ctrl_enable/ctrl_enabled handshake. The offload is always disabled and drained before its memory is reset or rewritten.

---
 rtl/ad5766_pkg.sv | 30 +++
 rtl/ad5766_offload_timer.sv | 41 ++++
 rtl/ad5766_offload_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ad5766_offload_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad5766_pkg.sv
// Shared definitions for the AD5766 offload command-memory sequencer:
// FSM state encodings, command word width and the program-length rule.
package ad5766_pkg;

  localparam int CMD_WORD_WIDTH = 16;

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_DISABLE = 3'd1;
  localparam logic [2:0] STATE_CLEAR   = 3'd2;
  localparam logic [2:0] STATE_LOAD    = 3'd3;
  localparam logic [2:0] STATE_LOADED  = 3'd4;
  localparam logic [2:0] STATE_ARM     = 3'd5;
  localparam logic [2:0] STATE_RUN     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = STATE_IDLE,
    S_DISABLE = STATE_DISABLE,
    S_CLEAR   = STATE_CLEAR,
    S_LOAD    = STATE_LOAD,
    S_LOADED  = STATE_LOADED,
    S_ARM     = STATE_ARM,
    S_RUN     = STATE_RUN
  } ctrl_state_e;

  // A program must hold at least one word and fit in the command memory.
  function automatic logic prog_len_valid(input int len, input int depth);
    return (len > 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/ad5766_offload_timer.sv
// Saturating cycle counter bounding the wait for the offload to report enabled.
module ad5766_offload_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired_o = (count_q == CNT_LAST);

  // Next count: clear wins, otherwise count up and hold at the last value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ad5766_offload_ctrl.sv
// AD5766 offload command-memory sequencer: drains the offload, clears and
// reloads the command memory from a word stream, then arms the offload.
module ad5766_offload_ctrl
  import ad5766_pkg::*;
#(
  parameter int CMD_MEM_ADDRESS_WIDTH = 4,
  parameter int ARM_TIMEOUT           = 1024
) (
  input  logic                           ctrl_clk,
  input  logic                           up_rstn,
  input  logic                           prog_start,
  input  logic [CMD_MEM_ADDRESS_WIDTH:0] prog_len,
  input  logic                           prog_word_valid,
  input  logic [CMD_WORD_WIDTH-1:0]      prog_word_data,
  output logic                           prog_word_ready,
  input  logic                           enable_req,
  input  logic                           disable_req,
  input  logic                           abort,
  output logic                           ctrl_cmd_wr_en,
  output logic [CMD_WORD_WIDTH-1:0]      ctrl_cmd_wr_data,
  output logic                           ctrl_mem_reset,
  output logic                           ctrl_enable,
  input  logic                           ctrl_enabled,
  output logic [2:0]                     state,
  output logic                           err
);

  localparam int LEN_W = CMD_MEM_ADDRESS_WIDTH + 1;
  localparam int DEPTH = 1 << CMD_MEM_ADDRESS_WIDTH;

  ctrl_state_e               state_q;
  ctrl_state_e               state_d;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          len_d;
  logic [LEN_W-1:0]          word_cnt_q;
  logic [LEN_W-1:0]          word_cnt_d;
  logic                      reload_q;
  logic                      reload_d;
  logic                      discard_q;
  logic                      discard_d;
  logic                      err_q;
  logic                      err_d;
  logic                      wr_en_q;
  logic                      wr_en_d;
  logic [CMD_WORD_WIDTH-1:0] wr_data_q;
  logic [CMD_WORD_WIDTH-1:0] wr_data_d;
  logic                      mem_reset_q;
  logic                      mem_reset_d;
  logic                      enable_q;
  logic                      enable_d;

  logic accept_s;
  logic len_ok_s;
  logic start_here_s;
  logic last_word_s;
  logic arm_expired_s;

  assign prog_word_ready = (state_q == S_LOAD);
  assign accept_s        = prog_word_valid & prog_word_ready;
  assign len_ok_s        = prog_len_valid(int'(prog_len), DEPTH);
  assign start_here_s    = (state_q == S_IDLE) || (state_q == S_LOADED) || (state_q == S_RUN);
  assign last_word_s     = (word_cnt_q == (len_q - LEN_W'(1)));

  ad5766_offload_timer #(
    .TIMEOUT (ARM_TIMEOUT)
  ) u_arm_timer (
    .clk_i     (ctrl_clk),
    .rstn_i    (up_rstn),
    .clear_i   (state_q != S_ARM),
    .en_i      (state_q == S_ARM),
    .expired_o (arm_expired_s)
  );

  // Next-state and registered-output decode; abort > prog_start > disable_req > enable_req.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    reload_d   = reload_q;
    discard_d  = discard_q;
    err_d      = 1'b0;
    wr_en_d    = accept_s;
    wr_data_d  = accept_s ? prog_word_data : wr_data_q;

    if (abort && (state_q != S_IDLE)) begin
      reload_d  = 1'b0;
      discard_d = 1'b1;
      state_d   = S_DISABLE;
    end else if (prog_start && start_here_s) begin
      if (len_ok_s) begin
        len_d    = prog_len;
        reload_d = 1'b1;
        state_d  = S_DISABLE;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        // No timeout here: the offload has to finish its current transfer.
        S_DISABLE: begin
          if (ctrl_enabled) begin
            state_d = S_DISABLE;
          end else if (reload_q) begin
            reload_d = 1'b0;
            state_d  = S_CLEAR;
          end else if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d = S_LOADED;
          end
        end
        S_CLEAR: begin
          word_cnt_d = '0;
          state_d    = S_LOAD;
        end
        S_LOAD: begin
          if (accept_s) begin
            word_cnt_d = word_cnt_q + LEN_W'(1);
            state_d    = last_word_s ? S_LOADED : S_LOAD;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOADED: state_d = enable_req ? S_ARM : S_LOADED;
        S_ARM: begin
          if (ctrl_enabled) begin
            state_d = S_RUN;
          end else if (arm_expired_s) begin
            err_d   = 1'b1;
            state_d = S_DISABLE;
          end else begin
            state_d = S_ARM;
          end
        end
        S_RUN: state_d = disable_req ? S_DISABLE : S_RUN;
        default: state_d = S_IDLE;
      endcase
    end

    mem_reset_d = (state_d == S_CLEAR);
    enable_d    = (state_d == S_ARM) || (state_d == S_RUN);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge ctrl_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      reload_q    <= 1'b0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      mem_reset_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      reload_q    <= reload_d;
      discard_q   <= discard_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      mem_reset_q <= mem_reset_d;
      enable_q    <= enable_d;
    end
  end

  assign state            = state_q;
  assign err              = err_q;
  assign ctrl_cmd_wr_en   = wr_en_q;
  assign ctrl_cmd_wr_data = wr_data_q;
  assign ctrl_mem_reset   = mem_reset_q;
  assign ctrl_enable      = enable_q;

endmodule

// File: tb/tb_ad5766_offload_ctrl.sv
// Bench for ad5766_offload_ctrl: program-length vector table, directed
// load/arm/reload/timeout/abort sequences and randomized reloads vs a word scoreboard.
module tb_ad5766_offload_ctrl;

  localparam int AW  = 4;
  localparam int TMO = 16;

  localparam logic [2:0] T_IDLE    = 3'd0;
  localparam logic [2:0] T_DISABLE = 3'd1;
  localparam logic [2:0] T_CLEAR   = 3'd2;
  localparam logic [2:0] T_LOAD    = 3'd3;
  localparam logic [2:0] T_LOADED  = 3'd4;
  localparam logic [2:0] T_ARM     = 3'd5;
  localparam logic [2:0] T_RUN     = 3'd6;

  typedef struct {
    logic       start;
    logic [4:0] len;
    logic       exp_err;
    logic [2:0] exp_state;
  } len_vec_t;

  logic        ctrl_clk = 1'b0;
  logic        up_rstn;
  logic        prog_start;
  logic [4:0]  prog_len;
  logic        prog_word_valid;
  logic [15:0] prog_word_data;
  logic        prog_word_ready;
  logic        enable_req;
  logic        disable_req;
  logic        abort;
  logic        ctrl_cmd_wr_en;
  logic [15:0] ctrl_cmd_wr_data;
  logic        ctrl_mem_reset;
  logic        ctrl_enable;
  logic        ctrl_enabled;
  logic [2:0]  state;
  logic        err;

  logic tie_en;
  logic force_en;
  assign ctrl_enabled = tie_en ? ctrl_enable : force_en;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] words [16];
  len_vec_t    vecs [7];

  always #5 ctrl_clk = ~ctrl_clk;

  ad5766_offload_ctrl #(
    .CMD_MEM_ADDRESS_WIDTH (AW),
    .ARM_TIMEOUT           (TMO)
  ) dut (
    .ctrl_clk         (ctrl_clk),
    .up_rstn          (up_rstn),
    .prog_start       (prog_start),
    .prog_len         (prog_len),
    .prog_word_valid  (prog_word_valid),
    .prog_word_data   (prog_word_data),
    .prog_word_ready  (prog_word_ready),
    .enable_req       (enable_req),
    .disable_req      (disable_req),
    .abort            (abort),
    .ctrl_cmd_wr_en   (ctrl_cmd_wr_en),
    .ctrl_cmd_wr_data (ctrl_cmd_wr_data),
    .ctrl_mem_reset   (ctrl_mem_reset),
    .ctrl_enable      (ctrl_enable),
    .ctrl_enabled     (ctrl_enabled),
    .state            (state),
    .err              (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ctrl_clk);
    #1;
  endtask

  // Scoreboard: every accept must produce exactly one write, next cycle, in order.
  task automatic feed_words(input int len, input int mode);
    int          idx      = 0;
    int          n_rst    = 0;
    int          rst_cyc  = -1;
    int          first_wr = -1;
    int          last_wr  = -1;
    bit          done     = 1'b0;
    bit          acc;
    logic [15:0] acc_data;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      case (mode)
        0:       prog_word_valid = 1'b1;
        1:       prog_word_valid = ((cyc % 2) == 0);
        default: prog_word_valid = 1'($urandom_range(0, 1));
      endcase
      prog_word_data = words[idx];
      acc            = prog_word_valid && prog_word_ready;
      acc_data       = words[idx];
      step();
      check("wr_en_follows_accept", ctrl_cmd_wr_en, acc);
      if (ctrl_mem_reset) begin
        n_rst++;
        rst_cyc = cyc;
        check("mem_reset_in_clear", state, T_CLEAR);
      end
      if (acc) begin
        check("wr_data", ctrl_cmd_wr_data, acc_data);
        if (first_wr < 0) begin
          first_wr = cyc;
          check("first_write_gap", (rst_cyc >= 0) && (cyc - rst_cyc >= 2), 1);
        end
        last_wr = cyc;
        idx++;
        if (idx == len) begin
          done = 1'b1;
          check("loaded_on_last_write", state, T_LOADED);
        end
      end
    end
    prog_word_valid = 1'b0;
    check("load_completed", done, 1);
    check("mem_reset_pulses", n_rst, 1);
    if (mode == 0 && done) check("writes_back_to_back", last_wr - first_wr, len - 1);
  endtask

  task automatic run_load(input int len, input int mode);
    prog_len   = 5'(len);
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    feed_words(len, mode);
  endtask

  task automatic go_run();
    int n;
    enable_req = 1'b1;
    step();
    enable_req = 1'b0;
    n = 1;
    while (state != T_RUN && n < 2) begin
      step();
      n++;
    end
    check("run_within_2", state, T_RUN);
    check("enable_in_run", ctrl_enable, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_err;
    int rlen;

    vecs[0] = '{1'b1, 5'd0,  1'b1, T_IDLE};
    vecs[1] = '{1'b1, 5'd17, 1'b1, T_IDLE};
    vecs[2] = '{1'b1, 5'd31, 1'b1, T_IDLE};
    vecs[3] = '{1'b0, 5'd0,  1'b0, T_IDLE};
    vecs[4] = '{1'b1, 5'd16, 1'b0, T_DISABLE};
    vecs[5] = '{1'b1, 5'd1,  1'b0, T_DISABLE};
    vecs[6] = '{1'b1, 5'd5,  1'b0, T_DISABLE};

    up_rstn = 1'b0; prog_start = 1'b0; prog_len = 5'd0; prog_word_valid = 1'b0;
    prog_word_data = 16'h0000; enable_req = 1'b0; disable_req = 1'b0; abort = 1'b0;
    tie_en = 1'b1; force_en = 1'b0;
    for (int i = 0; i < 16; i++) words[i] = 16'h0000;

    repeat (2) @(posedge ctrl_clk);
    #1;
    check("rst_state", state, T_IDLE);
    check("rst_enable", ctrl_enable, 0);
    check("rst_mem_reset", ctrl_mem_reset, 0);
    check("rst_wr_en", ctrl_cmd_wr_en, 0);
    check("rst_wr_data", ctrl_cmd_wr_data, 0);
    check("rst_err", err, 0);
    check("rst_ready", prog_word_ready, 0);
    up_rstn = 1'b1;
    step();
    check("post_rst_state", state, T_IDLE);

    // Program-length rule from IDLE.
    for (int i = 0; i < 7; i++) begin
      prog_start = vecs[i].start;
      prog_len   = vecs[i].len;
      step();
      prog_start = 1'b0;
      check("len_vec_err", err, vecs[i].exp_err);
      check("len_vec_state", state, vecs[i].exp_state);
      if (vecs[i].exp_state == T_DISABLE) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("len_vec_abort_no_clear", ctrl_mem_reset, 0);
        step();
        check("len_vec_abort_idle", state, T_IDLE);
      end else begin
        step();
        check("len_vec_err_one_cycle", err, 0);
        check("len_vec_stay_idle", state, T_IDLE);
      end
    end

    // Load three words with valid held high, then arm.
    words[0] = 16'h1001; words[1] = 16'h1002; words[2] = 16'h1003;
    run_load(3, 0);
    disable_req = 1'b1;
    step();
    disable_req = 1'b0;
    check("disable_ignored_in_loaded", state, T_LOADED);
    go_run();

    // Reload while running: offload stays busy for 10 cycles after enable drops.
    tie_en = 1'b0; force_en = 1'b1;
    words[0] = 16'hA5A1; words[1] = 16'hA5A2;
    prog_len = 5'd2; prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    check("reload_disable", state, T_DISABLE);
    check("reload_enable_drops", ctrl_enable, 0);
    for (int k = 0; k < 10; k++) begin
      check("hold_no_mem_reset", ctrl_mem_reset, 0);
      check("hold_no_write", ctrl_cmd_wr_en, 0);
      check("hold_in_disable", state, T_DISABLE);
      step();
    end
    tie_en = 1'b1; force_en = 1'b0;
    feed_words(2, 0);

    // Backpressure: valid every other cycle.
    for (int i = 0; i < 4; i++) words[i] = 16'h2001 + 16'(i);
    run_load(4, 1);

    // Arm timeout with the offload never reporting enabled.
    tie_en = 1'b0; force_en = 1'b0;
    enable_req = 1'b1;
    step();
    enable_req = 1'b0;
    check("arm_entry", state, T_ARM);
    check("arm_enable", ctrl_enable, 1);
    first_err = -1;
    for (int k = 1; k <= 40 && first_err < 0; k++) begin
      step();
      if (err) first_err = k;
    end
    check("timeout_latency", first_err, TMO);
    check("timeout_state", state, T_DISABLE);
    check("timeout_enable_low", ctrl_enable, 0);
    step();
    check("timeout_err_one_cycle", err, 0);
    check("timeout_back_to_loaded", state, T_LOADED);
    check("timeout_enable_stays_low", ctrl_enable, 0);
    tie_en = 1'b1;

    // abort beats prog_start on the same cycle.
    abort = 1'b1; prog_start = 1'b1; prog_len = 5'd3;
    step();
    abort = 1'b0; prog_start = 1'b0;
    check("prio_disable", state, T_DISABLE);
    check("prio_no_err", err, 0);
    step();
    check("prio_idle", state, T_IDLE);
    check("prio_no_mem_reset", ctrl_mem_reset, 0);

    // abort during LOAD discards the program.
    prog_len = 5'd5; prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    n = 0;
    while (state != T_LOAD && n < 10) begin
      step();
      n++;
    end
    check("reach_load", state, T_LOAD);
    prog_word_valid = 1'b1; prog_word_data = 16'h3333;
    step();
    step();
    prog_word_valid = 1'b0;
    check("mid_load", state, T_LOAD);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_load_disable", state, T_DISABLE);
    step();
    check("abort_load_idle", state, T_IDLE);
    enable_req = 1'b1;
    step();
    enable_req = 1'b0;
    check("enable_ignored_idle", state, T_IDLE);
    check("enable_ignored_no_enable", ctrl_enable, 0);
    step();
    check("enable_ignored_still_idle", state, T_IDLE);

    // Randomized reloads from IDLE, LOADED and RUN with random valid gaps.
    for (int it = 0; it < 6; it++) begin
      rlen = int'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
      if (it > 0 && $urandom_range(0, 1) == 1) go_run();
      run_load(rlen, 2);
    end

    // Asynchronous reset while running drops enable immediately.
    go_run();
    #2;
    up_rstn = 1'b0;
    #1;
    check("async_rst_enable", ctrl_enable, 0);
    check("async_rst_state", state, T_IDLE);
    step();
    up_rstn = 1'b1;
    step();
    check("after_async_rst_state", state, T_IDLE);
    check("after_async_rst_wr_en", ctrl_cmd_wr_en, 0);
    check("after_async_rst_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
